// File: rtl/axioma_eeprom_pkg.sv
// rtl/axioma_eeprom_pkg.sv - EEPROM I/O register map, EECR bit layout and sequencer state encoding
package axioma_eeprom_pkg;

  localparam logic [5:0] IO_EECR  = 6'h1F;
  localparam logic [5:0] IO_EEDR  = 6'h20;
  localparam logic [5:0] IO_EEARL = 6'h21;
  localparam logic [5:0] IO_EEARH = 6'h22;

  localparam int EECR_EERE    = 0;
  localparam int EECR_EEPE    = 1;
  localparam int EECR_EEMPE   = 2;
  localparam int EECR_EERIE   = 3;
  localparam int EECR_EEPM_LO = 4;
  localparam int EECR_EEPM_HI = 5;

  localparam logic [1:0] EEPM_ERASE_WRITE = 2'b00;
  localparam logic [1:0] EEPM_ERASE       = 2'b01;
  localparam logic [1:0] EEPM_WRITE       = 2'b10;
  localparam logic [1:0] EEPM_RSVD        = 2'b11;

  localparam logic [2:0] STB_EERE  = 3'b001;
  localparam logic [2:0] STB_EEPE  = 3'b010;
  localparam logic [2:0] STB_EEMPE = 3'b100;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_POLL0 = 4'd1,
    S_AH    = 4'd2,
    S_AL    = 4'd3,
    S_RE    = 4'd4,
    S_POLL1 = 4'd5,
    S_RD    = 4'd6,
    S_DR    = 4'd7,
    S_MPE   = 4'd8,
    S_PE    = 4'd9,
    S_RSP   = 4'd10
  } seq_state_t;

  // EERIE is always written as 0 so the controller never raises its ready interrupt.
  function automatic logic [7:0] eecr_cmd(input logic [1:0] mode, input logic [2:0] strobe);
    return {2'b00, mode, 1'b0, strobe};
  endfunction

endpackage

// File: rtl/axioma_eeprom_seq.sv
// rtl/axioma_eeprom_seq.sv - request/response initiator running the EEAR/EEDR/EECR access sequence
module axioma_eeprom_seq
  import axioma_eeprom_pkg::*;
#(
  parameter logic [15:0] POLL_LIMIT = 16'd8192
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [1:0] req_mode,
  input  logic [9:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic [5:0] io_addr,
  output logic [7:0] io_data_out,
  input  logic [7:0] io_data_in,
  output logic       io_read,
  output logic       io_write,
  output logic [3:0] debug_state
);

  seq_state_t  state;
  logic        lat_write;
  logic [1:0]  lat_mode;
  logic [9:0]  lat_addr;
  logic [7:0]  lat_wdata;
  logic [15:0] poll_cnt;
  logic [7:0]  rdata_q;
  logic        rsp_valid_q;
  logic        rsp_err_q;

  logic [15:0] poll_cnt_inc;
  logic        poll0_done;
  logic        poll1_done;
  logic        poll_expired;

  assign poll_cnt_inc = poll_cnt + 16'd1;
  assign poll0_done   = (io_data_in[EECR_EEPE:EECR_EERE] == 2'b00);
  assign poll1_done   = lat_write ? !io_data_in[EECR_EEPE] : !io_data_in[EECR_EERE];
  assign poll_expired = (poll_cnt_inc >= POLL_LIMIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      lat_write   <= 1'b0;
      lat_mode    <= 2'b00;
      lat_addr    <= 10'd0;
      lat_wdata   <= 8'h00;
      poll_cnt    <= 16'd0;
      rdata_q     <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            lat_write <= req_write;
            lat_mode  <= req_mode;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            poll_cnt  <= 16'd0;
            rdata_q   <= 8'h00;
            rsp_err_q <= 1'b0;
            if (req_write && (req_mode == EEPM_RSVD)) begin
              state       <= S_RSP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end else begin
              state <= S_POLL0;
            end
          end
        end
        S_POLL0: begin
          if (poll0_done) begin
            state <= S_AH;
          end else begin
            poll_cnt <= poll_cnt_inc;
            if (poll_expired) begin
              state       <= S_RSP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end
          end
        end
        S_AH: state <= S_AL;
        S_AL: state <= lat_write ? S_DR : S_RE;
        S_RE: begin
          state    <= S_POLL1;
          poll_cnt <= 16'd0;
        end
        S_DR:  state <= S_MPE;
        // PE must land within the 4-cycle EEMPE window, so it follows MPE directly.
        S_MPE: state <= S_PE;
        S_PE: begin
          state    <= S_POLL1;
          poll_cnt <= 16'd0;
        end
        S_POLL1: begin
          if (poll1_done) begin
            if (lat_write) begin
              state       <= S_RSP;
              rsp_valid_q <= 1'b1;
            end else begin
              state <= S_RD;
            end
          end else begin
            poll_cnt <= poll_cnt_inc;
            if (poll_expired) begin
              state       <= S_RSP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end
          end
        end
        S_RD: begin
          rdata_q     <= io_data_in;
          state       <= S_RSP;
          rsp_valid_q <= 1'b1;
        end
        S_RSP:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Bus strobes decode straight from the state so an async reset drops them at once.
  always_comb begin
    io_addr     = 6'h00;
    io_data_out = 8'h00;
    io_read     = 1'b0;
    io_write    = 1'b0;
    case (state)
      S_POLL0, S_POLL1: begin
        io_read = 1'b1;
        io_addr = IO_EECR;
      end
      S_AH: begin
        io_write    = 1'b1;
        io_addr     = IO_EEARH;
        io_data_out = {6'b000000, lat_addr[9:8]};
      end
      S_AL: begin
        io_write    = 1'b1;
        io_addr     = IO_EEARL;
        io_data_out = lat_addr[7:0];
      end
      S_RE: begin
        io_write    = 1'b1;
        io_addr     = IO_EECR;
        io_data_out = eecr_cmd(2'b00, STB_EERE);
      end
      S_RD: begin
        io_read = 1'b1;
        io_addr = IO_EEDR;
      end
      S_DR: begin
        io_write    = 1'b1;
        io_addr     = IO_EEDR;
        io_data_out = lat_wdata;
      end
      S_MPE: begin
        io_write    = 1'b1;
        io_addr     = IO_EECR;
        io_data_out = eecr_cmd(lat_mode, STB_EEMPE);
      end
      S_PE: begin
        io_write    = 1'b1;
        io_addr     = IO_EECR;
        io_data_out = eecr_cmd(lat_mode, STB_EEPE);
      end
      default: ;
    endcase
  end

  assign req_ready   = (state == S_IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = rsp_err_q;
  assign debug_state = state;

endmodule

// File: tb/tb_axioma_eeprom_seq.sv
// tb/tb_axioma_eeprom_seq.sv - directed bench for axioma_eeprom_seq against a behavioural EEPROM controller
`timescale 1ns/1ps
module tb_axioma_eeprom_seq;
  import axioma_eeprom_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req_valid, req_ready, req_write;
  logic [1:0] req_mode;
  logic [9:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid, rsp_err;
  logic [7:0] rsp_rdata;
  logic [5:0] io_addr;
  logic [7:0] io_data_out, io_data_in;
  logic       io_read, io_write;
  logic [3:0] debug_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axioma_eeprom_seq #(.POLL_LIMIT(16'd16)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_mode(req_mode), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .io_addr(io_addr), .io_data_out(io_data_out), .io_data_in(io_data_in),
    .io_read(io_read), .io_write(io_write), .debug_state(debug_state)
  );

  // Behavioural EEPROM controller: EERE busy 2 cycles, EEPE busy 6 cycles, 4-cycle EEMPE window.
  logic [7:0] mem [0:1023];
  logic [1:0] m_eearh, m_eepm;
  logic [7:0] m_eearl, m_eedr;
  logic       m_eempe, m_eepe, m_eere;
  int         mpe_tmr, busy_tmr, re_tmr;
  logic       stuck = 1'b0;
  logic       pl_en = 1'b0;
  logic [9:0] pl_addr = 10'd0;
  logic [7:0] pl_data = 8'h00;
  logic [9:0] m_addr;
  assign m_addr = {m_eearh, m_eearl};

  always_comb begin
    io_data_in = 8'h00;
    case (io_addr)
      IO_EECR:  io_data_in = {2'b00, m_eepm, 1'b0, m_eempe, m_eepe | stuck, m_eere};
      IO_EEDR:  io_data_in = m_eedr;
      IO_EEARL: io_data_in = m_eearl;
      IO_EEARH: io_data_in = {6'b000000, m_eearh};
      default:  ;
    endcase
  end

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (!reset_n) begin
      m_eearh <= 2'b00; m_eearl <= 8'h00; m_eedr <= 8'h00; m_eepm <= 2'b00;
      m_eempe <= 1'b0; m_eepe <= 1'b0; m_eere <= 1'b0;
      mpe_tmr <= 0; busy_tmr <= 0; re_tmr <= 0;
    end else begin
      if (m_eere) begin
        if (re_tmr == 0) begin
          m_eere <= 1'b0;
          m_eedr <= mem[m_addr];
        end else re_tmr <= re_tmr - 1;
      end
      if (m_eepe) begin
        if (busy_tmr == 0) begin
          m_eepe <= 1'b0;
          case (m_eepm)
            2'b00:   mem[m_addr] <= m_eedr;
            2'b01:   mem[m_addr] <= 8'hFF;
            2'b10:   mem[m_addr] <= mem[m_addr] & m_eedr;
            default: ;
          endcase
        end else busy_tmr <= busy_tmr - 1;
      end
      if (m_eempe) begin
        if (mpe_tmr == 0) m_eempe <= 1'b0;
        else mpe_tmr <= mpe_tmr - 1;
      end
      if (io_write) begin
        case (io_addr)
          IO_EEARH: m_eearh <= io_data_out[1:0];
          IO_EEARL: m_eearl <= io_data_out;
          IO_EEDR:  m_eedr  <= io_data_out;
          IO_EECR: begin
            m_eepm <= io_data_out[5:4];
            if (io_data_out[2]) begin
              m_eempe <= 1'b1;
              mpe_tmr <= 3;
            end else if (io_data_out[1] && m_eempe) begin
              m_eepe   <= 1'b1;
              busy_tmr <= 5;
              m_eempe  <= 1'b0;
            end
            if (io_data_out[0] && !m_eepe) begin
              m_eere <= 1'b1;
              re_tmr <= 1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Bus monitor, sampled mid-cycle.
  logic [5:0] wa_q[$];
  logic [7:0] wd_q[$];
  int         wc_q[$];
  int         eecr_reads = 0;
  int         overlap = 0;

  always @(negedge clk) begin
    if (io_write) begin
      wa_q.push_back(io_addr);
      wd_q.push_back(io_data_out);
      wc_q.push_back(cyc);
    end
    if (io_read && io_addr == IO_EECR) eecr_reads++;
    if (io_read && io_write) overlap++;
  end

  task automatic clear_log();
    wa_q.delete(); wd_q.delete(); wc_q.delete();
    eecr_reads = 0;
  endtask

  task automatic preload(input logic [9:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic do_req(input logic w, input logic [1:0] m, input logic [9:0] a, input logic [7:0] d,
                        output logic got, output logic [7:0] rd, output logic e, output int lat);
    int t0;
    @(negedge clk);
    clear_log();
    req_write = w; req_mode = m; req_addr = a; req_wdata = d; req_valid = 1'b1;
    t0 = cyc;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_write = ~w; req_mode = ~m; req_addr = ~a; req_wdata = ~d;
    got = 1'b0; rd = 8'hXX; e = 1'bX; lat = -1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1'b1; rd = rsp_rdata; e = rsp_err; lat = cyc - t0;
      end
    end
  endtask

  task automatic test_reset();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %0b exp 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %0b exp 0", rsp_valid); end
    checks++; if (rsp_err !== 1'b0 || rsp_rdata !== 8'h00) begin errors++; $display("FAIL reset_rsp got err=%0b rdata=%h exp 0/00", rsp_err, rsp_rdata); end
    checks++; if (io_read !== 1'b0 || io_write !== 1'b0) begin errors++; $display("FAIL reset_strobes got rd=%0b wr=%0b exp 0/0", io_read, io_write); end
    checks++; if (io_addr !== 6'h00 || io_data_out !== 8'h00) begin errors++; $display("FAIL reset_bus got addr=%h data=%h exp 00/00", io_addr, io_data_out); end
    checks++; if (debug_state !== 4'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", debug_state); end
  endtask

  task automatic test_read_after_reset();
    logic got, e; logic [7:0] rd; int lat;
    logic [5:0] ea[3] = '{IO_EEARH, IO_EEARL, IO_EECR};
    logic [7:0] ed[3] = '{8'h03, 8'hFF, 8'h01};
    preload(10'h3FF, 8'hFF);
    do_req(1'b0, 2'b00, 10'h3FF, 8'h00, got, rd, e, lat);
    checks++; if (!got) begin errors++; $display("FAIL rd_rsp no response within bound"); end
    checks++; if (rd !== 8'hFF) begin errors++; $display("FAIL rd_rdata got %h exp ff", rd); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL rd_err got %0b exp 0", e); end
    checks++; if (lat !== 9) begin errors++; $display("FAIL rd_latency got %0d exp 9", lat); end
    checks++; if (eecr_reads !== 4) begin errors++; $display("FAIL rd_polls got %0d exp 4", eecr_reads); end
    checks++; if (wa_q.size() !== 3) begin errors++; $display("FAIL rd_nwrites got %0d exp 3", wa_q.size()); end
    for (int i = 0; i < 3 && i < wa_q.size(); i++) begin
      checks++;
      if (wa_q[i] !== ea[i] || wd_q[i] !== ed[i]) begin
        errors++; $display("FAIL rd_write%0d got %h=%h exp %h=%h", i, wa_q[i], wd_q[i], ea[i], ed[i]);
      end
    end
  endtask

  task automatic test_erase_write();
    logic got, e; logic [7:0] rd; int lat;
    logic [5:0] ea[5] = '{IO_EEARH, IO_EEARL, IO_EEDR, IO_EECR, IO_EECR};
    logic [7:0] ed[5] = '{8'h01, 8'h55, 8'hA5, 8'h04, 8'h02};
    do_req(1'b1, 2'b00, 10'h155, 8'hA5, got, rd, e, lat);
    checks++; if (!got || e !== 1'b0 || rd !== 8'h00) begin errors++; $display("FAIL ew_rsp got valid=%0b err=%0b rdata=%h exp 1/0/00", got, e, rd); end
    checks++; if (lat !== 14) begin errors++; $display("FAIL ew_latency got %0d exp 14", lat); end
    checks++; if (wa_q.size() !== 5) begin errors++; $display("FAIL ew_nwrites got %0d exp 5", wa_q.size()); end
    for (int i = 0; i < 5 && i < wa_q.size(); i++) begin
      checks++;
      if (wa_q[i] !== ea[i] || wd_q[i] !== ed[i]) begin
        errors++; $display("FAIL ew_write%0d got %h=%h exp %h=%h", i, wa_q[i], wd_q[i], ea[i], ed[i]);
      end
    end
    if (wc_q.size() == 5) begin
      checks++; if (wc_q[4] !== wc_q[3] + 1) begin errors++; $display("FAIL ew_mpe_pe_gap got %0d exp 1", wc_q[4] - wc_q[3]); end
    end
    do_req(1'b0, 2'b00, 10'h155, 8'h00, got, rd, e, lat);
    checks++; if (!got || rd !== 8'hA5 || e !== 1'b0) begin errors++; $display("FAIL ew_readback got valid=%0b rdata=%h err=%0b exp 1/a5/0", got, rd, e); end
  endtask

  task automatic test_write_only_and();
    logic got, e; logic [7:0] rd; int lat;
    preload(10'h010, 8'hF0);
    do_req(1'b1, 2'b10, 10'h010, 8'h3C, got, rd, e, lat);
    checks++; if (!got || e !== 1'b0) begin errors++; $display("FAIL wo_rsp got valid=%0b err=%0b exp 1/0", got, e); end
    checks++; if (wa_q.size() !== 5) begin errors++; $display("FAIL wo_nwrites got %0d exp 5", wa_q.size()); end
    if (wa_q.size() == 5) begin
      checks++; if (wd_q[3] !== 8'h24 || wd_q[4] !== 8'h22) begin errors++; $display("FAIL wo_eecr got %h,%h exp 24,22", wd_q[3], wd_q[4]); end
      checks++; if (wd_q[0] !== 8'h00 || wd_q[1] !== 8'h10 || wd_q[2] !== 8'h3C) begin errors++; $display("FAIL wo_addr_data got %h,%h,%h exp 00,10,3c", wd_q[0], wd_q[1], wd_q[2]); end
    end
    do_req(1'b0, 2'b00, 10'h010, 8'h00, got, rd, e, lat);
    checks++; if (!got || rd !== 8'h30) begin errors++; $display("FAIL wo_readback got valid=%0b rdata=%h exp 1/30", got, rd); end
  endtask

  task automatic test_reserved_mode();
    logic got, e; logic [7:0] rd; int lat;
    do_req(1'b1, 2'b11, 10'h2AA, 8'h55, got, rd, e, lat);
    checks++; if (!got || lat !== 1) begin errors++; $display("FAIL rsvd_latency got valid=%0b lat=%0d exp 1/1", got, lat); end
    checks++; if (e !== 1'b1 || rd !== 8'h00) begin errors++; $display("FAIL rsvd_rsp got err=%0b rdata=%h exp 1/00", e, rd); end
    checks++; if (wa_q.size() !== 0 || eecr_reads !== 0) begin errors++; $display("FAIL rsvd_bus got writes=%0d reads=%0d exp 0/0", wa_q.size(), eecr_reads); end
  endtask

  task automatic test_timeout();
    logic got, e; logic [7:0] rd; int lat;
    stuck = 1'b1;
    do_req(1'b0, 2'b00, 10'h001, 8'h00, got, rd, e, lat);
    stuck = 1'b0;
    checks++; if (eecr_reads !== 16) begin errors++; $display("FAIL to_polls got %0d exp 16", eecr_reads); end
    checks++; if (!got || e !== 1'b1 || rd !== 8'h00) begin errors++; $display("FAIL to_rsp got valid=%0b err=%0b rdata=%h exp 1/1/00", got, e, rd); end
    checks++; if (lat !== 17) begin errors++; $display("FAIL to_latency got %0d exp 17", lat); end
    checks++; if (wa_q.size() !== 0) begin errors++; $display("FAIL to_writes got %0d exp 0", wa_q.size()); end
  endtask

  task automatic test_reset_mid_sequence();
    logic got, e, found; logic [7:0] rd; int lat;
    @(negedge clk);
    req_write = 1'b1; req_mode = 2'b00; req_addr = 10'h020; req_wdata = 8'h5A; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (debug_state == S_POLL1) found = 1'b1;
    end
    checks++; if (!found || io_read !== 1'b1) begin errors++; $display("FAIL mid_reach_poll1 got found=%0b rd=%0b exp 1/1", found, io_read); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (io_read !== 1'b0 || io_write !== 1'b0) begin errors++; $display("FAIL mid_strobes got rd=%0b wr=%0b exp 0/0", io_read, io_write); end
    checks++; if (req_ready !== 1'b1 || debug_state !== 4'd0) begin errors++; $display("FAIL mid_idle got ready=%0b state=%0d exp 1/0", req_ready, debug_state); end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    do_req(1'b0, 2'b00, 10'h3FF, 8'h00, got, rd, e, lat);
    checks++; if (!got || rd !== 8'hFF || e !== 1'b0 || lat !== 9) begin errors++; $display("FAIL mid_new_read got valid=%0b rdata=%h err=%0b lat=%0d exp 1/ff/0/9", got, rd, e, lat); end
  endtask

  task automatic test_no_overlap();
    checks++; if (overlap !== 0) begin errors++; $display("FAIL strobe_overlap got %0d exp 0", overlap); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_mode = 2'b00; req_addr = 10'd0; req_wdata = 8'h00;
    repeat (3) @(negedge clk);
    test_reset();
    reset_n = 1'b1;
    test_read_after_reset();
    test_erase_write();
    test_write_only_and();
    test_reserved_mode();
    test_timeout();
    test_reset_mid_sequence();
    test_no_overlap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axioma_eeprom_seq.md
# axioma_eeprom_seq

I/O-bus initiator that drives the EEPROM register interface (EEARL/EEARH/EEDR/EECR) on behalf of a simple request/response client. It sits between an internal master and the EEPROM controller's I/O port. Examples of such a master are a boot loader, a debug unit or a fuse-shadow loader. For each request it performs the ATmega328P-compatible access sequence:

- poll for idle;
- load the address;
- for a read, strobe EERE and fetch EEDR;
- for a write, load EEDR and issue EEMPE then EEPE.

It returns one response per request.

## Interface
Parameters:
- POLL_LIMIT, 16'd8192: maximum EECR poll reads per poll phase before a timeout error.

Ports:
- clk  in  1  system clock. One clock domain; reset is asynchronous and active-low.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready.
- req_write  in  1  1 = write/erase, 0 = read.
- req_mode  in  2  EEPM[1:0] for writes: 00 erase+write, 01 erase, 10 write-only, 11 reserved.
- req_addr  in  10  EEPROM byte address.
- req_wdata  in  8  write data.
- rsp_valid  out  1  one-cycle response pulse; there is no backpressure.
- rsp_rdata  out  8  read data, valid with rsp_valid. Holds 8'h00 for writes and errors.
- rsp_err  out  1  valid with rsp_valid: timeout or reserved mode.
- io_addr  out  6  I/O address: EECR 6'h1F, EEDR 6'h20, EEARL 6'h21, EEARH 6'h22.
- io_data_out  out  8  write data to the peripheral.
- io_data_in  in  8  combinational read data from the peripheral.
- io_read  out  1  read strobe.
- io_write  out  1  write strobe.
- debug_state  out  4  current FSM state.

## Operation
- The request fields are latched on acceptance. Later changes on req_* are ignored until IDLE is reached again.
- A write with req_mode=11 produces no bus activity. The next cycle gives rsp_valid=1 and rsp_err=1, then the FSM returns to IDLE.
- States and the bus activity each one drives:
  - IDLE: no bus activity.
  - POLL0: io_read EECR; repeat until io_data_in[1:0]==2'b00.
  - AH: write EEARH = {6'b0, addr[9:8]}.
  - AL: write EEARL = addr[7:0].
  - Read path:
    - RE: write EECR = 8'h01.
    - POLL1: io_read EECR until bit0==0.
    - RD: io_read EEDR; capture io_data_in into rsp_rdata.
    - RSP.
  - Write path:
    - DR: write EEDR = wdata.
    - MPE: write EECR = {2'b00, mode, 4'b0100}.
    - PE: write EECR = {2'b00, mode, 4'b0010}.
    - POLL1: io_read EECR until bit1==0.
    - RSP.
- RSP: pulse rsp_valid, then go to IDLE.
- PE always follows MPE in the very next cycle, which meets the 4-cycle EEMPE window. EERIE is always written as 0.
- Poll counter:
  - 16 bits; cleared on entry to each poll state; increments once per poll read.
  - If the counter reaches POLL_LIMIT without the exit condition, go to RSP with rsp_err=1 and rsp_rdata=8'h00.
- io_addr, io_data_out, io_read and io_write are Moore decodes of the state register plus the latched request.
  - They are 0 outside the states listed above.
  - io_read and io_write are never both high.

## Timing
- Reset values: all outputs 0 except req_ready=1. State is IDLE and the counter is 0.
- Reset asserted mid-sequence drops the strobes immediately and returns to IDLE. It does not wait for the peripheral.
- Read, peripheral idle:
  - accept at T0;
  - POLL0 at T1;
  - AH at T2, AL at T3, RE at T4;
  - POLL1 from T5 until clear;
  - RD the cycle after the clearing poll;
  - rsp_valid the cycle after RD.
- Write, peripheral idle:
  - AH at T2, AL at T3, DR at T4, MPE at T5, PE at T6;
  - POLL1 from T7;
  - rsp_valid the cycle after the poll read that sees EEPE=0.
- A poll exit is decided from io_data_in sampled in the same cycle as io_read.
- req_ready is low from the cycle after acceptance through the RSP cycle. It returns high the cycle after rsp_valid.

## Structure
- Shared package axioma_eeprom_pkg holds:
  - I/O address localparams (EECR/EEDR/EEARL/EEARH);
  - EECR bit indices (EERE=0, EEPE=1, EEMPE=2, EERIE=3, EEPM=5:4);
  - EEPM mode codes;
  - the sequencer state encoding (4 bits).
- The EEPROM controller imports the same package.
- Single module, no sub-module. The poll counter is inline.

## Test plan
- **Read after reset:** the EEPROM model holds 8'hFF at 10'h3FF; read addr 10'h3FF.
  - Required: EEARH=8'h03 then EEARL=8'hFF, then EECR=8'h01.
  - Required: rsp_rdata=8'hFF, rsp_err=0.
- **Erase+write, then read back:** erase+write addr 10'h155 data 8'hA5, mode 00.
  - Required: EECR writes 8'h04 then 8'h02 in consecutive cycles.
  - Required: the response arrives after the write cycle completes; a read of 10'h155 returns 8'hA5.
- **Write-only AND:** pre-load 8'hF0 at addr 10'h010, then write-only (mode 10) with 8'h3C.
  - Required: EECR writes 8'h24 then 8'h22.
  - Required: a read-back returns 8'h30.
- **Reserved mode:** write with req_mode=11.
  - Required: no io_write; rsp_valid the next cycle with rsp_err=1.
- **Timeout:** peripheral stub holds EECR bit1=1; POLL_LIMIT=16'd16.
  - Required: exactly 16 poll reads, then rsp_err=1 and rsp_rdata=8'h00.
- **Reset mid-sequence:** assert reset_n=0 during POLL1 of a write.
  - Required: io_write/io_read drop to 0 asynchronously and req_ready=1.
  - Required: a new read is accepted after reset release.
